atu_pipe_arbiter: RTL and testbench

Sequencer that shares the address translation unit between the patch (BHU) request pipe and the pixel ld/st request pipe. It drives the unit's mutually exclusive `patch_select` / `pix_select` lines and gates each pipe's data-available ack into the unit, so that only the granted pipe can pop. It tracks requests in flight through the unit and switches the grant only after the unit has fully drained. Arbitration is round-robin with a bounded burst per grant.

---
 rtl/atu_pipe_arbiter_if.sv | 38 +++
 rtl/atu_pipe_arbiter.sv | 143 ++++++++++++++
 tb/tb_atu_pipe_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/atu_pipe_arbiter_if.sv
// ---------------------------------------------------------------------------
// atu_pipe_arbiter_if
//   Handshake bundle between the ATU, its two request pipes (patch / pix) and
//   the arbiter that sequences them.
//   slave  : arbiter side (monitors the unit's strobes, drives gated acks,
//            selects and busy)
//   master : unit/pipe side (drives fifo acks and the unit's strobes,
//            observes the arbiter outputs)
// ---------------------------------------------------------------------------
interface atu_pipe_arbiter_if;
    logic patch_fifo_ack;       // patch pipe has data
    logic pix_fifo_ack;         // pix pipe has data
    logic patch_pipe_read_req;  // unit pops the patch pipe
    logic pix_pipe_read_req;    // unit pops the pix pipe
    logic pipe_write_req;       // unit output request
    logic pipe_write_ack;       // output accept
    logic patch_pipe_read_ack;  // gated ack into the unit (patch)
    logic pix_pipe_read_ack;    // gated ack into the unit (pix)
    logic patch_select;         // unit works on the patch pipe
    logic pix_select;           // unit works on the pix pipe
    logic busy;                 // requests in flight inside the unit

    modport slave (
        input  patch_fifo_ack, pix_fifo_ack,
        input  patch_pipe_read_req, pix_pipe_read_req,
        input  pipe_write_req, pipe_write_ack,
        output patch_pipe_read_ack, pix_pipe_read_ack,
        output patch_select, pix_select, busy
    );

    modport master (
        output patch_fifo_ack, pix_fifo_ack,
        output patch_pipe_read_req, pix_pipe_read_req,
        output pipe_write_req, pipe_write_ack,
        input  patch_pipe_read_ack, pix_pipe_read_ack,
        input  patch_select, pix_select, busy
    );
endinterface

// File: rtl/atu_pipe_arbiter.sv
// ---------------------------------------------------------------------------
// atu_pipe_arbiter
//   Shares the address translation unit between the patch (BHU) request pipe
//   and the pixel ld/st request pipe. Round-robin with a bounded burst per
//   grant; the grant only moves once every request in flight has completed.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   atu (slave)     fifo acks / unit strobes in; gated acks, selects, busy out
//   patch_done_cnt  completed patch transactions  (ATU_ARB_STATS_EN only)
//   pix_done_cnt    completed pix transactions    (ATU_ARB_STATS_EN only)
//
// Build option: define ATU_ARB_STATS_EN to add the completion counters.
// ---------------------------------------------------------------------------
module atu_pipe_arbiter #(
    parameter int BURST_LEN = 8,   // 1..255 pops per grant under contention
    parameter int OUT_W     = 3    // outstanding-request counter width
`ifdef ATU_ARB_STATS_EN
    , parameter int CNT_W   = 16   // statistics counter width
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    atu_pipe_arbiter_if.slave atu
`ifdef ATU_ARB_STATS_EN
    , output logic [CNT_W-1:0] patch_done_cnt
    , output logic [CNT_W-1:0] pix_done_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, PATCH, PIX, DRAIN} state_t;

    localparam logic [7:0]       BURST_MAX = 8'(BURST_LEN);
    localparam logic [OUT_W-1:0] OUT_MAX   = '1;

    state_t           state, state_nxt;
    logic             last_patch, last_patch_nxt;  // previous grant: 1=patch, 0=pix
    logic [7:0]       burst_cnt, burst_nxt;
    logic [OUT_W-1:0] outstanding, out_nxt;
    logic             patch_sel_q, pix_sel_q, busy_q;
    logic             pop, cpl, burst_hit, entering;

    // Gated acks: only the granted pipe can be popped.
    assign atu.patch_pipe_read_ack = atu.patch_fifo_ack & (state == PATCH);
    assign atu.pix_pipe_read_ack   = atu.pix_fifo_ack   & (state == PIX);
    assign atu.patch_select        = patch_sel_q;
    assign atu.pix_select          = pix_sel_q;
    assign atu.busy                = busy_q;

    assign pop = ((state == PATCH) & atu.patch_pipe_read_req) |
                 ((state == PIX)   & atu.pix_pipe_read_req);
    assign cpl = atu.pipe_write_req & atu.pipe_write_ack;

    // Burst limit includes the pop of this cycle, so the BURST_LEN-th pop
    // is the last one: the grant leaves on that same edge.
    assign burst_hit = (burst_cnt == BURST_MAX) ||
                       (pop && (burst_cnt == BURST_MAX - 8'd1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (atu.patch_fifo_ack)    state_nxt = PATCH;
                else if (atu.pix_fifo_ack) state_nxt = PIX;
            end
            PATCH: begin
                if (atu.pix_fifo_ack && (burst_hit || !atu.patch_fifo_ack))
                    state_nxt = DRAIN;
            end
            PIX: begin
                if (atu.patch_fifo_ack && (burst_hit || !atu.pix_fifo_ack))
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                // Unit empty: prefer the other pipe, else give it back.
                if (outstanding == '0) begin
                    if (last_patch) state_nxt = atu.pix_fifo_ack   ? PIX   : PATCH;
                    else            state_nxt = atu.patch_fifo_ack ? PATCH : PIX;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        last_patch_nxt = last_patch;
        if (state_nxt == PATCH)    last_patch_nxt = 1'b1;
        else if (state_nxt == PIX) last_patch_nxt = 1'b0;

        entering = ((state_nxt == PATCH) || (state_nxt == PIX)) && (state_nxt != state);

        burst_nxt = burst_cnt;
        if (entering)                             burst_nxt = '0;
        else if (pop && (burst_cnt != BURST_MAX)) burst_nxt = burst_cnt + 8'd1;

        // Pop and completion in one cycle cancel; no wrap in either direction.
        out_nxt = outstanding;
        if (pop && !cpl) begin
            if (outstanding != OUT_MAX) out_nxt = outstanding + OUT_W'(1);
        end else if (cpl && !pop) begin
            if (outstanding != '0)      out_nxt = outstanding - OUT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_patch  <= 1'b0;   // "last = PIX" so a first tie goes to patch
            burst_cnt   <= '0;
            outstanding <= '0;
            patch_sel_q <= 1'b0;
            pix_sel_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            last_patch  <= last_patch_nxt;
            burst_cnt   <= burst_nxt;
            outstanding <= out_nxt;
            // Selects follow the next state; DRAIN keeps the old owner so the
            // unit can finish its writes. Exclusive by construction.
            patch_sel_q <= (state_nxt == PATCH) || ((state_nxt == DRAIN) &&  last_patch_nxt);
            pix_sel_q   <= (state_nxt == PIX)   || ((state_nxt == DRAIN) && !last_patch_nxt);
            busy_q      <= (out_nxt != '0);
        end
    end

`ifdef ATU_ARB_STATS_EN
    // Completions are credited to whichever select is live in that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            patch_done_cnt <= '0;
            pix_done_cnt   <= '0;
        end else if (cpl) begin
            if (patch_sel_q) begin
                if (patch_done_cnt != '1) patch_done_cnt <= patch_done_cnt + CNT_W'(1);
            end else if (pix_sel_q) begin
                if (pix_done_cnt != '1)   pix_done_cnt   <= pix_done_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_atu_pipe_arbiter.sv
module tb_atu_pipe_arbiter;
    localparam int BL = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    atu_pipe_arbiter_if atu ();

`ifdef ATU_ARB_STATS_EN
    logic [3:0] patch_done_cnt, pix_done_cnt;
    atu_pipe_arbiter #(.BURST_LEN(BL), .OUT_W(3), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .atu(atu),
        .patch_done_cnt(patch_done_cnt), .pix_done_cnt(pix_done_cnt));
`else
    atu_pipe_arbiter #(.BURST_LEN(BL), .OUT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .atu(atu));
`endif

    int n_tests = 0, n_fail = 0;

    // stimulus-owned
    bit unit_en = 1'b0;
    int patch_tot = 0, pix_tot = 0;

    // unit-model-owned
    int cyc = 0, patch_pops = 0, pix_pops = 0;
    bit pop_q[$];
    int both_cnt = 0, sw_bad = 0, gap_cnt = 0, pblk = 0, xblk = 0, orphan = 0;
    int last_patch_cpl = 0, pix_rise = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    // Unit + pipe model: a pipe offers data while its total is not yet
    // popped; the unit pops whenever the gated ack is live and completes
    // each pop two cycles later.
    initial begin
        logic [1:0] sr;
        logic pp, xp, prev_busy, prev_ps, prev_xs;
        sr = 2'b00; prev_busy = 1'b0; prev_ps = 1'b0; prev_xs = 1'b0;
        atu.patch_fifo_ack = 1'b0;      atu.pix_fifo_ack = 1'b0;
        atu.patch_pipe_read_req = 1'b0; atu.pix_pipe_read_req = 1'b0;
        atu.pipe_write_req = 1'b0;      atu.pipe_write_ack = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            atu.patch_fifo_ack = (patch_pops < patch_tot);
            atu.pix_fifo_ack   = (pix_pops < pix_tot);
            #1;
            pp = unit_en && rst_n && atu.patch_pipe_read_ack;
            xp = unit_en && rst_n && atu.pix_pipe_read_ack;
            atu.patch_pipe_read_req = pp;
            atu.pix_pipe_read_req   = xp;
            if (pp) begin patch_pops++; pop_q.push_back(1'b1); end
            if (xp) begin pix_pops++;   pop_q.push_back(1'b0); end
            atu.pipe_write_req = rst_n && sr[1];
            sr = rst_n ? {sr[0], pp | xp} : 2'b00;
            if (atu.patch_select && atu.pix_select) both_cnt++;
            if (atu.pipe_write_req) begin
                if (atu.patch_select)    last_patch_cpl = cyc;
                else if (!atu.pix_select) orphan++;
            end
            if (atu.pix_select && !prev_xs) begin
                pix_rise = cyc;
                if (prev_busy) sw_bad++;
            end
            if (atu.patch_select && !prev_ps && prev_busy) sw_bad++;
            if (rst_n && prev_ps && !atu.patch_select && !atu.pix_select) gap_cnt++;
            if (rst_n && prev_xs && !atu.pix_select && !atu.patch_select) gap_cnt++;
            if (atu.patch_select && atu.patch_fifo_ack && !atu.patch_pipe_read_ack) pblk++;
            if (atu.pix_select && atu.pix_fifo_ack && !atu.pix_pipe_read_ack) xblk++;
            prev_busy = atu.busy; prev_ps = atu.patch_select; prev_xs = atu.pix_select;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input string tag, input int max);
        int  n;
        logic done;
        n = 0; done = 1'b0;
        while (!done && n < max) begin
            tick(1);
            n++;
            done = (patch_pops == patch_tot) && (pix_pops == pix_tot) && !atu.busy;
        end
        chk(tag, done, 1);
    endtask

    initial begin
        int q0, s0, g0, b0, pb0, xb0, errs, p0, x0;
        // ---- reset values
        #2;
        chk("rst_patch_sel", atu.patch_select, 0);
        chk("rst_pix_sel",   atu.pix_select, 0);
        chk("rst_busy",      atu.busy, 0);
        chk("rst_patch_ack", atu.patch_pipe_read_ack, 0);
        chk("rst_pix_ack",   atu.pix_pipe_read_ack, 0);

        // ---- grant latency from IDLE, then a parked patch grant
        do_reset();
        unit_en = 1'b0;
        patch_tot = patch_pops + 5;
        tick(1);
        chk("grant_pre_sel", atu.patch_select, 0);
        tick(1);
        chk("grant_patch_sel", atu.patch_select, 1);
        chk("grant_patch_ack", atu.patch_pipe_read_ack, 1);
        chk("grant_pix_sel",   atu.pix_select, 0);
        p0 = patch_pops;
        unit_en = 1'b1;
        wait_done("t1_done", 50);
        chk("t1_pops", patch_pops - p0, 5);

        // ---- both pipes busy: bursts of BL alternate, drain between
        do_reset();
        q0 = pop_q.size(); b0 = both_cnt; s0 = sw_bad; g0 = gap_cnt; pb0 = pblk; xb0 = xblk;
        patch_tot += 24; pix_tot += 24;
        wait_done("alt_done", 300);
        chk("alt_pops", pop_q.size() - q0, 48);
        errs = 0;
        for (int i = 0; i < 48 && q0 + i < pop_q.size(); i++)
            if (pop_q[q0 + i] != (((i / BL) % 2) == 0)) errs++;
        chk("alt_order", errs, 0);
        chk("alt_both_sel", both_cnt - b0, 0);
        chk("alt_switch_busy", sw_bad - s0, 0);
        chk("alt_sel_gap", gap_cnt - g0, 0);
        chk("alt_patch_drain_cyc", pblk - pb0, 6);
        chk("alt_pix_drain_cyc", xblk - xb0, 6);

        // ---- patch ack drops after 3 pops while pix waits
        do_reset();
        p0 = patch_pops; x0 = pix_pops; s0 = sw_bad; g0 = gap_cnt;
        patch_tot += 3; pix_tot += 7;
        wait_done("drop_done", 100);
        chk("drop_patch_pops", patch_pops - p0, 3);
        chk("drop_pix_pops", pix_pops - x0, 7);
        chk("drop_switch_lat", pix_rise - last_patch_cpl, 2);
        chk("drop_switch_busy", sw_bad - s0, 0);
        chk("drop_sel_gap", gap_cnt - g0, 0);

        // ---- pix only, 300 pops: stays parked, never blocked
        do_reset();
        x0 = pix_pops; xb0 = xblk; q0 = pop_q.size();
        pix_tot += 300;
        wait_done("park_done", 400);
        chk("park_pops", pix_pops - x0, 300);
        chk("park_no_drain", xblk - xb0, 0);
        errs = 0;
        for (int i = q0; i < pop_q.size(); i++) if (pop_q[i]) errs++;
        chk("park_only_pix", errs, 0);

        // ---- async reset with a request in flight
        do_reset();
        p0 = patch_pops;
        patch_tot = patch_pops + 3;
        errs = 0;
        while (patch_pops == p0 && errs < 10) begin tick(1); errs++; end
        chk("rst_mid_popped", patch_pops - p0, 1);
        unit_en = 1'b0;
        @(posedge clk); #2;
        chk("rst_mid_busy", atu.busy, 1);
        chk("rst_mid_ack", atu.patch_pipe_read_ack, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_patch_sel", atu.patch_select, 0);
        chk("rst_async_pix_sel", atu.pix_select, 0);
        chk("rst_async_patch_ack", atu.patch_pipe_read_ack, 0);
        chk("rst_async_busy", atu.busy, 0);
        patch_tot = patch_pops;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        chk("rst_rel_patch_sel", atu.patch_select, 0);
        chk("rst_rel_pix_sel", atu.pix_select, 0);
        chk("rst_rel_busy", atu.busy, 0);
        pix_tot = pix_pops + 1;
        tick(2);
        chk("rst_rel_idle_grant", atu.pix_select, 1);
        pix_tot = pix_pops;

        // ---- completion attribution
        do_reset();
        unit_en = 1'b1;
        o_check_init: begin end
        p0 = patch_pops; x0 = pix_pops; g0 = orphan;
        patch_tot += 5;
        wait_done("st_patch_done", 50);
        pix_tot += 7;
        wait_done("st_pix_done", 50);
        chk("st_patch_pops", patch_pops - p0, 5);
        chk("st_pix_pops", pix_pops - x0, 7);
        chk("st_cpl_unselected", orphan - g0, 0);
`ifdef ATU_ARB_STATS_EN
        chk("st_patch_cnt", patch_done_cnt, 5);
        chk("st_pix_cnt", pix_done_cnt, 7);
        pix_tot += 13;
        wait_done("st_sat_done", 80);
        chk("st_pix_cnt_sat", pix_done_cnt, 15);
        chk("st_patch_cnt_hold", patch_done_cnt, 5);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d cycles, expected completion", cyc);
        $fatal(1, "timeout");
    end
endmodule
